// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: select codes, FSM states, default width.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAR   = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester and serial-stream signals of shift_seq_ctrl; slave = controller, master = requesters/sink.
// Handshake: a requester holds reqN with stable dataN until the cycle gntN=1, which is the
// acceptance; ser_out/ser_last/ser_src are meaningful only when ser_valid=1 (no backpressure).
interface shift_seq_ctrl_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_src;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, ser_out, ser_valid, ser_last, ser_src
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, ser_out, ser_valid, ser_last, ser_src
  );
endinterface

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && (!req1 || last_gnt)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer/arbiter for the 4-bit universal shift register: load granted word, shift it out MSB-first.
// Optional trailing even-parity bit when SHIFT_SEQ_PARITY_EN is defined.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] u,
  input  logic             t3,
  output logic             busy,
  output state_t           state_dbg
);
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             src_q;
  logic             gnt0_w;
  logic             gnt1_w;
  logic             ser_out_c;
  logic             ser_valid_c;
  logic             ser_last_c;

  // Grants are masked during reset so nothing is accepted in a reset cycle.
  rr_arb2 u_arb (
    .req0     (bus.req0),
    .req1     (bus.req1),
    .last_gnt (last_gnt),
    .en       ((state == ST_IDLE) && reset),
    .gnt0     (gnt0_w),
    .gnt1     (gnt1_w)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      u        <= '0;
      src_q    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt0_w) begin
        u        <= bus.data0;
        src_q    <= 1'b0;
        last_gnt <= 1'b0;
      end else if (gnt1_w) begin
        u        <= bus.data1;
        src_q    <= 1'b1;
        last_gnt <= 1'b1;
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
      end else if (state == ST_SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    sel         = SEL_HOLD;
    ser_out_c   = 1'b0;
    ser_valid_c = 1'b0;
    ser_last_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt0_w || gnt1_w) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        sel       = SEL_LOAD;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        sel         = SEL_SHL;
        ser_out_c   = t3;
        ser_valid_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_SEQ_PARITY_EN
          state_nxt  = ST_PAR;
`else
          ser_last_c = 1'b1;
          state_nxt  = ST_IDLE;
`endif
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      // u still holds the word captured at grant, so parity needs no datapath readback.
      ST_PAR: begin
        ser_out_c   = ^u;
        ser_valid_c = 1'b1;
        ser_last_c  = 1'b1;
        state_nxt   = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.gnt0      = gnt0_w;
  assign bus.gnt1      = gnt1_w;
  assign bus.ser_out   = ser_out_c;
  assign bus.ser_valid = ser_valid_c;
  assign bus.ser_last  = ser_last_c;
  assign bus.ser_src   = src_q;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W = 4;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int FRAME = W + 3;
`else
  localparam int FRAME = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel;
  logic [W-1:0] u;
  logic         t3;
  logic         busy;
  state_t       state_dbg;
  logic [W-1:0] dp_q;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .sel       (sel),
    .u         (u),
    .t3        (t3),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Datapath: 00 hold, 01 shift left zero fill, 10 parallel load.
  always @(posedge clk) begin
    case (sel)
      2'b10:   dp_q <= u;
      2'b01:   dp_q <= {dp_q[W-2:0], 1'b0};
      default: dp_q <= dp_q;
    endcase
  end
  assign t3 = dp_q[W-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    #1;
    n_checks++; if (sel !== SEL_HOLD) $display("FAIL reset_sel: got %b want 00", sel); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); else n_pass++;
    n_checks++; if ({bus.ser_out, bus.ser_valid, bus.ser_last, bus.ser_src} !== 4'b0000)
      $display("FAIL reset_ser: got %b want 0000", {bus.ser_out, bus.ser_valid, bus.ser_last, bus.ser_src}); else n_pass++;
    n_checks++; if (u !== '0) $display("FAIL reset_u: got %h want 0", u); else n_pass++;
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      cyc();
      #1;
      n_checks++;
      if ({sel, bus.gnt0, bus.gnt1, bus.ser_valid} !== 5'b0)
        $display("FAIL idle_quiet: cycle %0d got %b want 00000", c, {sel, bus.gnt0, bus.gnt1, bus.ser_valid});
      else n_pass++;
    end
  endtask

  // Requester 0 alone, two words back to back with req0 held across the first grant.
  task automatic test_single();
    logic [W-1:0] words [2];
    logic [W-1:0] d;
    words[0] = 4'b1011;
    words[1] = 4'b0111;
    cyc();
    bus.req0 = 1'b1;
    bus.data0 = words[0];
    #1;
    for (int w = 0; w < 2; w++) begin
      d = words[w];
      n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) $display("FAIL single_gnt: word %0d got %b want 10", w, {bus.gnt0, bus.gnt1}); else n_pass++;
      cyc();
      if (w == 0) bus.data0 = words[1];
      else bus.req0 = 1'b0;
      #1;
      n_checks++; if (sel !== SEL_LOAD) $display("FAIL single_load_sel: got %b want 10", sel); else n_pass++;
      n_checks++; if (u !== d) $display("FAIL single_load_u: got %b want %b", u, d); else n_pass++;
      for (int i = 0; i < W; i++) begin
        cyc();
        #1;
        n_checks++; if (bus.ser_out !== d[W-1-i] || bus.ser_valid !== 1'b1)
          $display("FAIL single_bit: word %0d bit %0d got %b/%b want %b/1", w, i, bus.ser_out, bus.ser_valid, d[W-1-i]); else n_pass++;
`ifdef SHIFT_SEQ_PARITY_EN
        n_checks++; if (bus.ser_last !== 1'b0) $display("FAIL single_last: bit %0d got %b want 0", i, bus.ser_last); else n_pass++;
`else
        n_checks++; if (bus.ser_last !== (i == W - 1)) $display("FAIL single_last: bit %0d got %b want %b", i, bus.ser_last, (i == W - 1)); else n_pass++;
`endif
        n_checks++; if (bus.ser_src !== 1'b0 || sel !== SEL_SHL) $display("FAIL single_src_sel: got %b/%b want 0/01", bus.ser_src, sel); else n_pass++;
      end
`ifdef SHIFT_SEQ_PARITY_EN
      cyc();
      #1;
      n_checks++; if ({bus.ser_out, bus.ser_valid, bus.ser_last, sel} !== {^d, 2'b11, SEL_HOLD})
        $display("FAIL single_parity: got %b want %b", {bus.ser_out, bus.ser_valid, bus.ser_last, sel}, {^d, 2'b11, SEL_HOLD}); else n_pass++;
`endif
      cyc();
      #1;
    end
    n_checks++; if (busy !== 1'b0 || bus.ser_valid !== 1'b0) $display("FAIL single_end: busy %b valid %b want 0/0", busy, bus.ser_valid); else n_pass++;
  endtask

  // Both requesters held: grants must alternate 0,1,0 with a new frame every FRAME cycles.
  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic         src;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 4'hA;
    bus.data1 = 4'h5;
    #1;
    for (int f = 0; f < 3; f++) begin
      src = (f == 1);
      d = src ? 4'h5 : 4'hA;
      n_checks++; if ({bus.gnt0, bus.gnt1} !== {~src, src}) $display("FAIL b2b_gnt: frame %0d got %b want %b", f, {bus.gnt0, bus.gnt1}, {~src, src}); else n_pass++;
      cyc();
      #1;
      n_checks++; if (u !== d) $display("FAIL b2b_u: frame %0d got %h want %h", f, u, d); else n_pass++;
      for (int i = 0; i < W; i++) begin
        cyc();
        #1;
        n_checks++; if (bus.ser_out !== d[W-1-i] || bus.ser_src !== src)
          $display("FAIL b2b_bit: frame %0d bit %0d got %b src %b want %b src %b", f, i, bus.ser_out, bus.ser_src, d[W-1-i], src); else n_pass++;
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b00) $display("FAIL b2b_busy_gnt: frame %0d got %b want 00", f, {bus.gnt0, bus.gnt1}); else n_pass++;
      end
`ifdef SHIFT_SEQ_PARITY_EN
      cyc();
      #1;
      n_checks++; if (bus.ser_out !== ^d || bus.ser_last !== 1'b1) $display("FAIL b2b_parity: frame %0d got %b/%b want %b/1", f, bus.ser_out, bus.ser_last, ^d); else n_pass++;
`endif
      cyc();
      if (f == 2) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      #1;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy); else n_pass++;
  endtask

  // req1 arrives mid-frame of requester 0 and must wait until the frame ends.
  task automatic test_late_req();
    logic [W-1:0] d;
    d = 4'b0110;
    cyc();
    bus.req0 = 1'b1;
    bus.data0 = 4'b1101;
    #1;
    n_checks++; if (bus.gnt0 !== 1'b1) $display("FAIL late_gnt0: got %b want 1", bus.gnt0); else n_pass++;
    cyc();
    bus.req0 = 1'b0;
    cyc();
    cyc();
    bus.req1 = 1'b1;
    bus.data1 = d;
    #1;
    for (int c = 3; c < FRAME; c++) begin
      n_checks++; if (bus.gnt1 !== 1'b0) $display("FAIL late_wait: cycle N+%0d got gnt1 %b want 0", c, bus.gnt1); else n_pass++;
      cyc();
      #1;
    end
    n_checks++; if (bus.gnt1 !== 1'b1) $display("FAIL late_gnt1: cycle N+%0d got %b want 1", FRAME, bus.gnt1); else n_pass++;
    cyc();
    bus.req1 = 1'b0;
    #1;
    for (int i = 0; i < W; i++) begin
      cyc();
      #1;
      n_checks++; if (bus.ser_out !== d[W-1-i] || bus.ser_src !== 1'b1)
        $display("FAIL late_bit: bit %0d got %b src %b want %b src 1", i, bus.ser_out, bus.ser_src, d[W-1-i]); else n_pass++;
    end
`ifdef SHIFT_SEQ_PARITY_EN
    cyc();
`endif
    cyc();
    #1;
  endtask

  // Reset during the second bit abandons the frame; the next frame must be clean.
  task automatic test_reset_mid();
    logic [W-1:0] d;
    d = 4'b1001;
    cyc();
    bus.req0 = 1'b1;
    bus.data0 = 4'b1100;
    #1;
    cyc();
    bus.req0 = 1'b0;
    cyc();
    #1;
    n_checks++; if (bus.ser_out !== 1'b1 || bus.ser_valid !== 1'b1) $display("FAIL mid_bit0: got %b/%b want 1/1", bus.ser_out, bus.ser_valid); else n_pass++;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    n_checks++; if (sel !== SEL_HOLD || busy !== 1'b0) $display("FAIL mid_abort: sel %b busy %b want 00/0", sel, busy); else n_pass++;
    n_checks++; if (bus.ser_last !== 1'b0 || bus.ser_valid !== 1'b0) $display("FAIL mid_noframe: last %b valid %b want 0/0", bus.ser_last, bus.ser_valid); else n_pass++;
    cyc();
    bus.req1 = 1'b1;
    bus.data1 = d;
    #1;
    n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) $display("FAIL mid_regnt: got %b want 01", {bus.gnt0, bus.gnt1}); else n_pass++;
    cyc();
    bus.req1 = 1'b0;
    #1;
    for (int i = 0; i < W; i++) begin
      cyc();
      #1;
      n_checks++; if (bus.ser_out !== d[W-1-i]) $display("FAIL mid_rebit: bit %0d got %b want %b", i, bus.ser_out, d[W-1-i]); else n_pass++;
    end
`ifdef SHIFT_SEQ_PARITY_EN
    cyc();
    #1;
`endif
    n_checks++; if (bus.ser_last !== 1'b1) $display("FAIL mid_relast: got %b want 1", bus.ser_last); else n_pass++;
    cyc();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_end_busy: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    dp_q = '0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_late_req();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer and two-port arbiter for the 4-bit universal shift register datapath. It accepts 4-bit words from two requesters using round-robin arbitration, drives the datapath `sel`/`U` inputs to parallel-load each granted word, then shifts the word out MSB-first. It presents the datapath's T3 output as a framed serial stream.

## Interface
Parameters:
- `WIDTH`, 4: word width. Must equal the datapath width.
- `CNT_W`, 2: bit-counter width, equal to clog2(`WIDTH`).

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-low; the block resets on any edge where `reset`==0.
- `req0` in 1: requester 0 has a word pending.
- `data0` in `WIDTH`: requester 0 word; must stay stable while `req0`=1.
- `req1` in 1: requester 1 has a word pending.
- `data1` in `WIDTH`: requester 1 word.
- `gnt0` out 1: one-cycle acceptance pulse for requester 0.
- `gnt1` out 1: one-cycle acceptance pulse for requester 1.
- `sel` out 2: datapath select. 00 = hold, 01 = shift left (zero fill), 10 = parallel load.
- `u` out `WIDTH`: datapath parallel-load word.
- `t3` in 1: datapath MSB (T3).
- `ser_out` out 1: serial data.
- `ser_valid` out 1: `ser_out` is valid this cycle.
- `ser_last` out 1: last bit of the frame.
- `ser_src` out 1: index of the requester that owns the current frame.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, PAR (PAR exists only with the macro defined).
- IDLE:
  - `sel`=00.
  - If any `req` is high, pick a winner:
    - Only one requester high: it wins.
    - Both high: the requester not granted last time wins.
  - `gnt_k` is asserted combinationally in that same cycle.
  - At the edge: `u` <= `data_k`, `ser_src` <= k, `last_gnt` <= k, state -> LOAD.
- Requester rules: drop `req` or change `data` only after the `gnt` cycle. `req` held high after `gnt` is a new request.
- LOAD: `sel`=10 with `u` driven; the datapath captures the word. State -> SHIFT, `cnt` <= 0.
- SHIFT:
  - `sel`=01, `ser_out`=`t3`, `ser_valid`=1.
  - `cnt` increments each cycle.
  - When `cnt`==`WIDTH`-1: `ser_last`=1 and next state is IDLE (or PAR with the macro).
- `gnt` is never asserted outside IDLE. Requests arriving while busy wait.
- `ser_valid`, `ser_last` and `gnt*` are 0 in every cycle not listed above.

## Timing
- Request seen in IDLE at cycle N:
  - `gnt` at N.
  - `sel`=10 at N+1.
  - Bits MSB..LSB at N+2..N+5; `ser_last` at N+5.
  - IDLE again at N+6; the next `gnt` is possible at N+6.
- Throughput is one word per `WIDTH`+2 cycles (`WIDTH`+3 with parity).
- Reset values: state IDLE, `sel`=00, `u`=0, `gnt0`/`gnt1`=0, `ser_out`=0, `ser_valid`=0, `ser_last`=0, `ser_src`=0, `busy`=0, `cnt`=0, `last_gnt`=1 (so requester 0 wins the first tie).
- Reset mid-frame: the frame is abandoned with no `ser_last`, and `sel`=00 from the next edge. The datapath keeps stale contents; the next LOAD overwrites them.
- Both requesters held high continuously: grants alternate 0,1,0,1, and no requester waits more than one frame.
- `req` dropping in the grant cycle is ignored, because the grant is already taken.

## Configuration
- `SHIFT_SEQ_PARITY_EN` defined:
  - After the last data bit, state PAR emits one extra bit with `sel`=00.
  - `ser_out` = XOR of the captured `u` (even parity), `ser_valid`=1, `ser_last`=1.
  - `ser_last` is not asserted in SHIFT.
  - Frame is `WIDTH`+1 bits.
- Not defined: no PAR state, no parity logic; the frame is `WIDTH` bits and `ser_last` is on the LSB.

## Structure
- Shared package `shift_seq_pkg` holds:
  - Select codes: `SEL_HOLD`=2'b00, `SEL_SHL`=2'b01, `SEL_LOAD`=2'b10.
  - State encodings: IDLE, LOAD, SHIFT, PAR.
  - Default `WIDTH`=4.
- One sub-module, `rr_arb2`:
  - Inputs: `req0`, `req1`, `last_gnt`, `en`.
  - Outputs: combinational one-hot grant.
  - Instantiated with `en` = (state==IDLE).
- Bench instantiates this block plus the existing 4-bit shift register with `sel`/`U`/T3 wired through.

## Test plan
- Reset, then `req0`=1, `data0`=4'b1011 -> `gnt0` at N; `ser_out` 1,0,1,1 at N+2..N+5; `ser_last` at N+5; `ser_src`=0.
- `req0`=`req1`=1 held, `data0`=4'hA, `data1`=4'h5 -> frames 1010 (src 0), 0101 (src 1), 1010 (src 0), each 6 cycles apart.
- `req1` raised at cycle N+3 of a requester-0 frame -> no `gnt1` until N+6; `gnt1` at N+6.
- `reset`=0 at cycle N+3 of a frame -> from N+4: `sel`=00, `busy`=0, no `ser_last`. Next request completes normally with correct bits.
- With `SHIFT_SEQ_PARITY_EN` defined, `data0`=4'b0111 -> bits 0,1,1,1, then parity 1 with `ser_last`; next `gnt` at N+7.
- No requests for 20 cycles after reset -> `sel`=00, `gnt*`=0, `ser_valid`=0 throughout.
